// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: 128 KB RAM, memory-mapped UART FIFOs,
// and a free-running cycle counter with a 32-bit snapshot register.
module mem_io_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cpu_en,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_done,
  output logic        tx_overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] NEAR_FULL = (FIFO_AW + 1)'(DEPTH - 2);

  logic [7:0] ram_mem [0:(1 << RAM_AW) - 1];
  logic [7:0] tx_mem  [0:DEPTH - 1];
  logic [7:0] rx_mem  [0:DEPTH - 1];

  logic [FIFO_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [FIFO_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [31:0]      cnt_q, cnt_d, snap_q, snap_d;
  logic [7:0]       cpu_din_q, cpu_din_d;
  logic             program_done_q, program_done_d;
  logic             tx_overflow_q, tx_overflow_d;

  logic             is_ram, is_io, bus_rd, bus_wr;
  logic [2:0]       io_off;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic [FIFO_AW:0] tx_cnt;
  logic [7:0]       rx_head;
  logic             tx_push_req, tx_push, tx_pop, rx_push, rx_pop, ram_we;
  logic [7:0]       tx_push_data;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^cpu_a[31:18];

  assign is_ram = ~cpu_a[17];
  assign is_io  = cpu_a[17] & cpu_a[16];
  assign io_off = cpu_a[2:0];
  assign bus_rd = cpu_en & ~cpu_wr;
  assign bus_wr = cpu_en & cpu_wr;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[FIFO_AW] != tx_rd_q[FIFO_AW]) &&
                    (tx_wr_q[FIFO_AW-1:0] == tx_rd_q[FIFO_AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[FIFO_AW] != rx_rd_q[FIFO_AW]) &&
                    (rx_wr_q[FIFO_AW-1:0] == rx_rd_q[FIFO_AW-1:0]);
  assign tx_cnt   = tx_wr_q - tx_rd_q;
  assign rx_head  = rx_mem[rx_rd_q[FIFO_AW-1:0]];

  // UART streams use valid/ready: a byte moves on any edge where both are high;
  // valid and data are held until accepted, and ready never depends on valid.
  assign tx_valid       = ~tx_empty;
  assign tx_data        = tx_empty ? 8'h00 : tx_mem[tx_rd_q[FIFO_AW-1:0]];
  assign rx_ready       = ~rx_full;
  assign io_buffer_full = (tx_cnt >= NEAR_FULL);
  assign cpu_din        = cpu_din_q;
  assign program_done   = program_done_q;
  assign tx_overflow    = tx_overflow_q;

  always_comb begin
    cnt_d          = cnt_q + 32'd1;
    snap_d         = snap_q;
    cpu_din_d      = cpu_din_q;
    program_done_d = program_done_q;
    tx_overflow_d  = tx_overflow_q;
    tx_push_req    = 1'b0;
    tx_push_data   = 8'h00;
    ram_we         = 1'b0;
    rx_pop         = 1'b0;

    if (bus_wr) begin
      if (is_ram) begin
        ram_we = 1'b1;
      end else if (is_io) begin
        if (io_off == 3'd0 && cpu_dout != 8'h00) begin
          tx_push_req  = 1'b1;
          tx_push_data = cpu_dout;
        end else if (io_off == 3'd4) begin
          // Stop marker: the zero byte tells the host the program has ended.
          tx_push_req    = 1'b1;
          program_done_d = 1'b1;
        end
      end
    end

    if (bus_rd) begin
      if (is_ram) begin
        cpu_din_d = ram_mem[cpu_a[RAM_AW-1:0]];
      end else if (!is_io) begin
        cpu_din_d = 8'h00;
      end else begin
        case (io_off)
          3'd0: begin
            cpu_din_d = rx_empty ? 8'h00 : rx_head;
            rx_pop    = ~rx_empty;
          end
          3'd4: begin
            cpu_din_d = cnt_q[7:0];
            snap_d    = cnt_q;
          end
          3'd5:    cpu_din_d = snap_q[15:8];
          3'd6:    cpu_din_d = snap_q[23:16];
          3'd7:    cpu_din_d = snap_q[31:24];
          default: cpu_din_d = 8'h00;
        endcase
      end
    end

    tx_pop  = ~tx_empty & tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    tx_push = tx_push_req & (~tx_full | tx_pop);
    if (tx_push_req && !tx_push) tx_overflow_d = 1'b1;
    rx_push = rx_valid & ~rx_full;

    tx_wr_d = tx_wr_q + (FIFO_AW + 1)'(tx_push);
    tx_rd_d = tx_rd_q + (FIFO_AW + 1)'(tx_pop);
    rx_wr_d = rx_wr_q + (FIFO_AW + 1)'(rx_push);
    rx_rd_d = rx_rd_q + (FIFO_AW + 1)'(rx_pop);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_wr_q        <= '0;
      tx_rd_q        <= '0;
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      cnt_q          <= '0;
      snap_q         <= '0;
      cpu_din_q      <= '0;
      program_done_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      tx_wr_q        <= tx_wr_d;
      tx_rd_q        <= tx_rd_d;
      rx_wr_q        <= rx_wr_d;
      rx_rd_q        <= rx_rd_d;
      cnt_q          <= cnt_d;
      snap_q         <= snap_d;
      cpu_din_q      <= cpu_din_d;
      program_done_q <= program_done_d;
      tx_overflow_q  <= tx_overflow_d;
    end
  end

  // Storage arrays carry no reset; the pointers alone define FIFO contents.
  always_ff @(posedge clk_in) begin
    if (ram_we)  ram_mem[cpu_a[RAM_AW-1:0]] <= cpu_dout;
    if (tx_push) tx_mem[tx_wr_q[FIFO_AW-1:0]] <= tx_push_data;
    if (rx_push) rx_mem[rx_wr_q[FIFO_AW-1:0]] <= rx_data;
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: RAM, unmapped space, TX/RX FIFOs,
// cycle counter snapshot and wrap, stop write and asynchronous reset.
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        cpu_en, cpu_wr, tx_ready, rx_valid;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout, rx_data;
  logic [7:0]  cpu_din, tx_data;
  logic        io_buffer_full, tx_valid, rx_ready, program_done, tx_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] e;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .cpu_en(cpu_en), .cpu_a(cpu_a),
    .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .program_done(program_done), .tx_overflow(tx_overflow)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // One bus cycle: drive at negedge, leave the bus idle #1 after the edge.
  task automatic drive_bus(input logic en, input logic wr, input logic [31:0] a,
                           input logic [7:0] d);
    @(negedge clk_in);
    cpu_en = en; cpu_wr = wr; cpu_a = a; cpu_dout = d;
    @(posedge clk_in); #1;
    cpu_en = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(negedge clk_in);
    rx_data = b; rx_valid = 1'b1;
    if (rx_q.size() < 16) rx_q.push_back(b);
    @(posedge clk_in); #1;
    rx_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    cpu_en = 0; cpu_wr = 0; cpu_a = 0; cpu_dout = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    n_tests++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_din: got %h required 00", cpu_din); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b required 0", tx_valid); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
    n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready: got %b required 1", rx_ready); end
    n_tests++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL rst_iobf: got %b required 0", io_buffer_full); end
    n_tests++; if (program_done !== 1'b0) begin n_fail++; $display("FAIL rst_pdone: got %b required 0", program_done); end
    n_tests++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b required 0", tx_overflow); end
  endtask

  task automatic test_ram();
    logic [31:0] addrs[8];
    logic [7:0]  data[8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 32'(i) * 32'h2000 + 32'($urandom_range(16'h0100, 16'h1FFF));
      data[i]  = 8'($urandom_range(0, 255));
      drive_bus(1, 1, addrs[i], data[i]);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(data[i]);
      drive_bus(1, 0, addrs[i], 8'h00);
      e = exp_q.pop_front();
      n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL ram_rand[%0d]: got %h required %h", i, cpu_din, e); end
    end
    drive_bus(1, 1, 32'h0000_0010, 8'hA5);
    exp_q.push_back(8'hA5);
    drive_bus(1, 0, 32'h0000_0010, 8'h00);
    e = exp_q.pop_front();
    n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL ram_10: got %h required %h", cpu_din, e); end
    drive_bus(1, 1, 32'h0001_FFFF, 8'h3C);
    exp_q.push_back(8'h3C);
    drive_bus(1, 0, 32'h0001_FFFF, 8'h00);
    e = exp_q.pop_front();
    n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL ram_1ffff: got %h required %h", cpu_din, e); end
  endtask

  task automatic test_unmapped();
    drive_bus(1, 1, 32'h0000_0004, 8'h5A);
    drive_bus(1, 1, 32'h0002_0004, 8'h77);
    exp_q.push_back(8'h00);
    drive_bus(1, 0, 32'h0002_0004, 8'h00);
    e = exp_q.pop_front();
    n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL unmapped_rd: got %h required %h", cpu_din, e); end
    exp_q.push_back(8'h5A);
    drive_bus(1, 0, 32'h0000_0004, 8'h00);
    e = exp_q.pop_front();
    n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL ram_4_kept: got %h required %h", cpu_din, e); end
    drive_bus(1, 1, 32'h0000_0100, 8'h11);
    n_tests++; if (cpu_din !== 8'h5A) begin n_fail++; $display("FAIL din_hold_wr: got %h required 5a", cpu_din); end
    drive_bus(0, 0, 32'h0000_0010, 8'h00);
    n_tests++; if (cpu_din !== 8'h5A) begin n_fail++; $display("FAIL din_hold_en: got %h required 5a", cpu_din); end
    exp_q.push_back(8'h00);
    drive_bus(1, 0, 32'h0003_0001, 8'h00);
    e = exp_q.pop_front();
    n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL io_other: got %h required %h", cpu_din, e); end
  endtask

  task automatic test_tx();
    logic [7:0] b;
    tx_ready = 1'b0;
    exp_q.delete();
    drive_bus(1, 1, 32'h0003_0000, 8'h48); exp_q.push_back(8'h48);
    drive_bus(1, 1, 32'h0003_0000, 8'h00);
    drive_bus(1, 1, 32'h0003_0000, 8'h69); exp_q.push_back(8'h69);
    n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid_2: got %b required 1", tx_valid); end
    n_tests++; if (tx_data !== 8'h48) begin n_fail++; $display("FAIL tx_head: got %h required 48", tx_data); end
    n_tests++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL iobf_2: got %b required 0", io_buffer_full); end
    for (int i = 0; i < 11; i++) begin
      b = 8'($urandom_range(1, 255));
      drive_bus(1, 1, 32'h0003_0000, b); exp_q.push_back(b);
    end
    n_tests++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL iobf_13: got %b required 0", io_buffer_full); end
    b = 8'($urandom_range(1, 255));
    drive_bus(1, 1, 32'h0003_0000, b); exp_q.push_back(b);
    n_tests++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL iobf_14: got %b required 1", io_buffer_full); end
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(1, 255));
      drive_bus(1, 1, 32'h0003_0000, b); exp_q.push_back(b);
    end
    n_tests++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_16: got %b required 0", tx_overflow); end
    // Full FIFO with a pop and a push in the same edge.
    tx_ready = 1'b1;
    e = exp_q.pop_front();
    n_tests++; if (tx_data !== e) begin n_fail++; $display("FAIL tx_head_full: got %h required %h", tx_data, e); end
    drive_bus(1, 1, 32'h0003_0000, 8'h55); exp_q.push_back(8'h55);
    tx_ready = 1'b0;
    n_tests++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop: got %b required 0", tx_overflow); end
    n_tests++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL iobf_pushpop: got %b required 1", io_buffer_full); end
    drive_bus(1, 1, 32'h0003_0000, 8'hEE);
    n_tests++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_17: got %b required 1", tx_overflow); end
    tx_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      @(negedge clk_in);
      e = exp_q.pop_front();
      n_tests++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        n_fail++; $display("FAIL tx_drain[%0d]: got %b/%h required 1/%h", k, tx_valid, tx_data, e);
      end
    end
    @(negedge clk_in);
    tx_ready = 1'b0;
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_empty_after: got %b required 0", tx_valid); end
  endtask

  task automatic test_rx();
    logic [7:0] b;
    rx_q.delete();
    rx_send(8'h31);
    rx_send(8'h32);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(rx_q.size() > 0 ? rx_q.pop_front() : 8'h00);
      drive_bus(1, 0, 32'h0003_0000, 8'h00);
      e = exp_q.pop_front();
      n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL rx_rd[%0d]: got %h required %h", i, cpu_din, e); end
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        n_tests++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_15: got %b required 1", rx_ready); end
      end
      b = 8'($urandom_range(1, 255));
      rx_send(b);
    end
    n_tests++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_16: got %b required 0", rx_ready); end
    rx_send(8'hAB);
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(rx_q.size() > 0 ? rx_q.pop_front() : 8'h00);
      drive_bus(1, 0, 32'h0003_0000, 8'h00);
      e = exp_q.pop_front();
      n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL rx_full_rd[%0d]: got %h required %h", i, cpu_din, e); end
    end
    // Push and pop together on an empty FIFO: read sees 00, byte stays.
    rx_data = 8'h99; rx_valid = 1'b1;
    exp_q.push_back(8'h00);
    drive_bus(1, 0, 32'h0003_0000, 8'h00);
    rx_valid = 1'b0;
    rx_q.push_back(8'h99);
    e = exp_q.pop_front();
    n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL rx_empty_pushpop: got %h required %h", cpu_din, e); end
    exp_q.push_back(rx_q.pop_front());
    drive_bus(1, 0, 32'h0003_0000, 8'h00);
    e = exp_q.pop_front();
    n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL rx_kept: got %h required %h", cpu_din, e); end
  endtask

  task automatic test_counter();
    apply_reset();
    repeat (99) @(posedge clk_in);
    exp_q.push_back(8'd99);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      drive_bus(1, 0, 32'h0003_0004 + 32'(i), 8'h00);
      e = exp_q.pop_front();
      n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL cnt_byte[%0d]: got %h required %h", i, cpu_din, e); end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk_in);
    force dut.cnt_q = 32'hFFFF_FFFF;
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_a = 32'h0003_0004;
    #1 release dut.cnt_q;
    @(posedge clk_in); #1;
    cpu_en = 1'b0;
    n_tests++; if (cpu_din !== 8'hFF) begin n_fail++; $display("FAIL wrap_b0: got %h required ff", cpu_din); end
    for (int i = 1; i < 4; i++) exp_q.push_back(8'hFF);
    exp_q.push_back(8'h03);
    for (int i = 1; i < 4; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 7; i++) begin
      drive_bus(1, 0, 32'h0003_0004 + 32'((i + 1) % 4), 8'h00);
      e = exp_q.pop_front();
      n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL wrap_rd[%0d]: got %h required %h", i, cpu_din, e); end
    end
  endtask

  task automatic test_stop_reset();
    drive_bus(0, 1, 32'h0003_0004, 8'hFF);
    n_tests++; if (program_done !== 1'b0) begin n_fail++; $display("FAIL stop_en0: got %b required 0", program_done); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL stop_en0_tx: got %b required 0", tx_valid); end
    drive_bus(1, 1, 32'h0003_0004, 8'hFF);
    n_tests++; if (program_done !== 1'b1) begin n_fail++; $display("FAIL stop_done: got %b required 1", program_done); end
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin n_fail++; $display("FAIL stop_tx: got %b/%h required 1/00", tx_valid, tx_data); end
    drive_bus(1, 1, 32'h0003_0000, 8'h41);
    drive_bus(1, 1, 32'h0003_0000, 8'h42);
    tx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    drive_bus(1, 0, 32'h0000_0010, 8'h00);
    e = exp_q.pop_front();
    n_tests++; if (cpu_din !== e) begin n_fail++; $display("FAIL ram_after_rst: got %h required %h", cpu_din, e); end
    n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL mid_drain: got %b/%h required 1/41", tx_valid, tx_data); end
    @(negedge clk_in); #2;
    rst_n_in = 1'b0;
    #1;
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL arst_tx_valid: got %b required 0", tx_valid); end
    n_tests++; if (program_done !== 1'b0) begin n_fail++; $display("FAIL arst_pdone: got %b required 0", program_done); end
    n_tests++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL arst_din: got %h required 00", cpu_din); end
    n_tests++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL arst_ovf: got %b required 0", tx_overflow); end
    tx_ready = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_unmapped();
    test_tx();
    test_rx();
    test_counter();
    test_wrap();
    test_stop_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Responder end of the CPU's byte-wide memory bus: it decodes the address, write-enable and write-data the CPU drives. It serves 128 KB of RAM and the memory-mapped I/O window at 0x30000, and returns read data one cycle later. It also generates `io_buffer_full` from an internal UART-side TX FIFO, buffers received bytes in an RX FIFO, and keeps the free-running cycle counter.

## Interface
- `RAM_AW`, default 17: RAM byte-address width (128 KB).
- `FIFO_AW`, default 4: log2 depth of each of the TX and RX FIFOs (16 entries).
- `clk_in` in 1: single clock, rising edge.
- `rst_n_in` in 1: reset, asynchronous and active-low.
- `cpu_en` in 1: CPU ready. When low the bus is ignored: no RAM write, no FIFO push or pop, no snapshot.
- `cpu_a` in 32: CPU address. Only [17:0] is decoded.
- `cpu_wr` in 1: 1 = write, 0 = read.
- `cpu_dout` in 8: write data from the CPU.
- `cpu_din` out 8: read data to the CPU, registered.
- `io_buffer_full` out 1: TX FIFO near full.
- `tx_data` out 8: head of the TX FIFO.
- `tx_valid` out 1: TX FIFO not empty.
- `tx_ready` in 1: UART transmitter accepts `tx_data`.
- `rx_data` in 8: byte from the UART receiver.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: RX FIFO not full.
- `program_done` out 1: sticky; the program has written the stop address.
- `tx_overflow` out 1: sticky; a TX push was dropped because the FIFO was full.

## Operation
- The bus carries one transaction every cycle in which `cpu_en` is 1. There is no request strobe; the CPU holds an I/O read address for exactly one cycle per intended read.
- Address decode on `cpu_a[17:16]`:
  - 00 or 01: RAM at `cpu_a[16:0]`.
  - 10: unmapped. Reads return 0x00; writes are dropped.
  - 11: I/O, decoded on `cpu_a[2:0]`.
- RAM write: the byte is stored at the clock edge.
- RAM read: `cpu_din` holds the RAM byte at the next edge.
- RAM is a synchronous byte array and is not cleared by reset.
- I/O read at offset 0: pops the RX FIFO and `cpu_din` receives the head byte. If the RX FIFO is empty, `cpu_din` = 0x00 and nothing is popped.
- I/O write at offset 0: pushes `cpu_dout` into the TX FIFO. A write of 0x00 is ignored.
- I/O read at offset 4: `cpu_din` = counter[7:0], and the whole 32-bit counter value is latched into a snapshot in the same edge.
- I/O reads at offsets 5, 6 and 7: return snapshot bytes 1, 2 and 3.
- I/O write at offset 4: sets `program_done` and pushes 0x00 into the TX FIFO. This push is unconditional and ignores the zero filter.
- Other I/O offsets: reads return 0x00; writes are ignored.
- Cycle counter: 32 bits, counts +1 every clock from reset regardless of `cpu_en`, and wraps from 0xFFFFFFFF to 0.
- TX FIFO:
  - A push when full is dropped and sets `tx_overflow`.
  - A pop occurs on `tx_valid && tx_ready`.
  - A simultaneous push and pop keeps the count unchanged, including when the FIFO is full.
- RX FIFO:
  - A push occurs on `rx_valid && rx_ready`.
  - A simultaneous push and pop is legal, including when the FIFO is empty. When empty, the pop returns 0x00 and the pushed byte stays.
- `io_buffer_full` = TX count >= depth-2. The margin covers a CPU write already in flight.

## Timing
- Read latency is one cycle: the address is presented in cycle N and `cpu_din` is valid in cycle N+1.
- `cpu_din` holds its value when `cpu_en` = 0 or `cpu_wr` = 1.
- Write latency is zero: the data is committed at the edge that ends cycle N.
- A RAM read of an address in the cycle immediately after a write to it returns the new byte.
- `tx_valid`, `tx_data`, `rx_ready` and `io_buffer_full` are combinational from the registered FIFO state only; no comb path from `cpu_*`.
- FIFO pointers are FIFO_AW+1 bits with wrap-around; full = pointer MSBs differ and the low bits are equal.
- Reset values:
  - `cpu_din` = 0, `tx_valid` = 0, `tx_data` = 0.
  - `rx_ready` = 1, `io_buffer_full` = 0.
  - `program_done` = 0, `tx_overflow` = 0.
  - Counter = 0, snapshot = 0, both FIFOs empty.
- Reset asserted mid-operation: any in-flight read is abandoned and both FIFOs empty immediately (asynchronous).
- After reset is released, the first edge increments the counter to 1.

## Test plan
- RAM: write 0xA5 to 0x00010, then read 0x00010 on the next cycle -> `cpu_din` = 0xA5 one cycle later. Read 0x1FFFF after writing 0x3C there -> 0x3C.
- Unmapped: write 0x77 to 0x20004, then read it -> `cpu_din` = 0x00, and RAM[0x00004] is unchanged.
- TX path: with `tx_ready` = 0, write 'H' (0x48), 0x00 and 'i' (0x69) to 0x30000 -> TX count 2 and `tx_data` = 0x48. Push 14 nonzero bytes in total -> `io_buffer_full` = 1. A 17th push sets `tx_overflow`. With `tx_ready` = 1, the bytes drain in order.
- RX path: drive 0x31 then 0x32 on rx. Read 0x30000 three times -> 0x31, 0x32, 0x00. `rx_ready` deasserts after 16 unread bytes.
- Counter: 100 cycles after reset, read 0x30004..0x30007 -> the four bytes form 99 (the count at the byte-0 read edge), and bytes 1-3 are unaffected by counting in between. Preload near 0xFFFFFFFF in simulation -> the counter wraps to 0.
- Stop and `cpu_en`: with `cpu_en` = 0, write 0xFF to 0x30004 -> no effect. With `cpu_en` = 1 -> `program_done` = 1 and 0x00 appears on `tx_data`. Assert `rst_n_in` low mid-drain -> `tx_valid` = 0 and `program_done` = 0 asynchronously.
